// File: rtl/updown_counter_param.sv
// Parameterised up/down/bounce counter with programmable limits.
// The upper bound comes from DEF_HI or hi_limit, selected by hi_sel.
// Steps are suppressed while the limits are inconsistent (lo_limit > HI).
// A count outside [lo_limit, HI] is pulled back to the nearest limit on the
// next step, so the counter never wraps at 2^WIDTH.
module updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int DEF_HI = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic             hi_sel,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             lim_err
);

  localparam logic [WIDTH-1:0] DefHi = DEF_HI[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ModeUpWrap   = 2'b00,
    ModeDownWrap = 2'b01,
    ModeBounce   = 2'b10,
    ModeHold     = 2'b11
  } modeE;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] hiEff;
  logic             stepEn;
  modeE             modeSel;

  assign modeSel = modeE'(mode);
  assign hiEff   = hi_sel ? hi_limit : DefHi;
  assign lim_err = (lo_limit > hiEff);
  assign stepEn  = enable && (modeSel != ModeHold) && !lim_err;

  // Next-state: load beats a step; a step first clamps out-of-range counts,
  // then handles the single-value window, then applies the selected mode.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (stepEn) begin
      if (count_q > hiEff) begin
        count_d = hiEff;
      end else if (count_q < lo_limit) begin
        count_d = lo_limit;
      end else if (lo_limit == hiEff) begin
        tc_d = 1'b1;
      end else begin
        unique case (modeSel)
          ModeUpWrap: begin
            dir_d = 1'b0;
            if (count_q < hiEff) begin
              count_d = count_q + One;
            end else begin
              count_d = lo_limit;
            end
            tc_d = (count_d == hiEff);
          end
          ModeDownWrap: begin
            dir_d = 1'b1;
            if (count_q > lo_limit) begin
              count_d = count_q - One;
            end else begin
              count_d = hiEff;
            end
            tc_d = (count_d == lo_limit);
          end
          ModeBounce: begin
            if (!dir_q) begin
              if (count_q < hiEff) begin
                count_d = count_q + One;
              end else begin
                count_d = count_q - One;
                dir_d   = 1'b1;
              end
            end else begin
              if (count_q > lo_limit) begin
                count_d = count_q - One;
              end else begin
                count_d = count_q + One;
                dir_d   = 1'b0;
              end
            end
            tc_d = (count_d == hiEff) || (count_d == lo_limit);
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign tc    = tc_q;

endmodule
